// File: rtl/present80_dec_core_pkg.sv
// Shared PRESENT-80 decryption definitions: S-box tables, FSM encoding and
// the forward/inverse key-schedule steps used by present80_dec_core.
package present_pkg;

   localparam int ROUNDS_DEF = 31;

   localparam logic [3:0] SBOX [0:15] = '{
      4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
      4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
   };

   localparam logic [3:0] SBOX_INV [0:15] = '{
      4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
      4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
   };

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      KEYEXP = 3'd1,
      DEC    = 3'd2,
      FIN    = 3'd3,
      DONE   = 3'd4
   } fsm_state_e;

   // Forward schedule step: turns K(i) into K(i+1) using round counter i.
   function automatic logic [79:0] key_update(input logic [79:0] key, input logic [4:0] rc);
      logic [79:0] k;
      k = {key[18:0], key[79:19]};
      k[79:76] = SBOX[k[79:76]];
      k[19:15] = k[19:15] ^ rc;
      return k;
   endfunction

   // Exact inverse of key_update: turns K(i+1) back into K(i).
   function automatic logic [79:0] key_update_inv(input logic [79:0] key, input logic [4:0] rc);
      logic [79:0] k;
      k = key;
      k[19:15] = k[19:15] ^ rc;
      k[79:76] = SBOX_INV[k[79:76]];
      return {k[60:0], k[79:61]};
   endfunction

   function automatic logic [63:0] sbox_inv_layer(input logic [63:0] din);
      logic [63:0] d;
      d = 64'h0;
      for (int n = 0; n < 16; n++) begin
         d[6'(4*n) +: 4] = SBOX_INV[din[6'(4*n) +: 4]];
      end
      return d;
   endfunction

endpackage

// File: rtl/present80_dec_core_if.sv
// Job channels of the PRESENT-80 decryptor: ciphertext/key in, plaintext out.
// The core uses the slave view; the job source/sink uses the master view.
interface present80_dec_core_if;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_data;
   logic [79:0] in_key;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;

   modport master (
      output in_valid, in_data, in_key, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, in_key, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/present80_dec_core_inv_player.sv
// Inverse PRESENT bit permutation: input bit j lands on bit 4j mod 63,
// bit 63 passes straight through.
module present_inv_player (
   input  logic [63:0] din,
   output logic [63:0] dout
);

   // Pure wiring permutation, unrolled at elaboration.
   always_comb begin
      dout = 64'h0;
      for (int j = 0; j < 63; j++) begin
         dout[6'((4*j) % 63)] = din[6'(j)];
      end
      dout[63] = din[63];
   end

endmodule

// File: rtl/present80_dec_core.sv
// Iterative PRESENT-80 decryptor, one round per clock. Optional key cache
// (skips forward key expansion on a repeated key) under PRESENT_KEY_CACHE_EN.
module present80_dec_core
   import present_pkg::*;
#(
   parameter int ROUNDS = ROUNDS_DEF,
   parameter int RC_W   = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   present80_dec_core_if.slave  bus
);

   localparam logic [RC_W-1:0] RC_LAST = RC_W'(ROUNDS);
   localparam logic [RC_W-1:0] RC_ONE  = RC_W'(1);

   fsm_state_e       state_r;
   fsm_state_e       state_n;
   logic [63:0]      blk_r;
   logic [79:0]      key_r;
   logic [RC_W-1:0]  rc_r;
   logic [63:0]      out_data_r;
   logic             out_valid_r;
   logic             in_ready_r;

   logic             accept_s;
   logic             hit_s;
   logic [79:0]      hit_key_s;
   logic             rc_last_s;
   logic             rc_first_s;
   logic [79:0]      key_fwd_s;
   logic [79:0]      key_inv_s;
   logic [63:0]      perm_in_s;
   logic [63:0]      perm_out_s;
   logic [63:0]      dec_s;

   assign accept_s   = bus.in_valid && in_ready_r;
   assign rc_last_s  = (rc_r == RC_LAST);
   assign rc_first_s = (rc_r == RC_ONE);
   assign key_fwd_s  = key_update(key_r, 5'(rc_r));
   assign key_inv_s  = key_update_inv(key_r, 5'(rc_r));
   assign perm_in_s  = blk_r ^ key_r[79:16];
   assign dec_s      = sbox_inv_layer(perm_out_s);

   present_inv_player u_inv_player (
      .din  (perm_in_s),
      .dout (perm_out_s)
   );

`ifdef PRESENT_KEY_CACHE_EN
   logic        cache_vld_r;
   logic [79:0] cache_key_r;
   logic [79:0] cache_k32_r;

   assign hit_s     = cache_vld_r && (bus.in_key == cache_key_r);
   assign hit_key_s = cache_k32_r;

   // Key tag is taken at acceptance; K32 and the valid flag land when expansion ends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cache_vld_r <= 1'b0;
         cache_key_r <= 80'h0;
         cache_k32_r <= 80'h0;
      end else if (state_r == IDLE && accept_s && !hit_s) begin
         cache_vld_r <= 1'b0;
         cache_key_r <= bus.in_key;
      end else if (state_r == KEYEXP && rc_last_s) begin
         cache_vld_r <= 1'b1;
         cache_k32_r <= key_fwd_s;
      end else begin
         cache_vld_r <= cache_vld_r;
      end
   end
`else
   assign hit_s     = 1'b0;
   assign hit_key_s = 80'h0;
`endif

   // FSM state and registered in_ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         in_ready_r <= 1'b1;
      end else begin
         state_r    <= state_n;
         in_ready_r <= (state_n == IDLE);
      end
   end

   // Next-state decode.
   always_comb begin
      state_n = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_n = hit_s ? DEC : KEYEXP;
            end else begin
               state_n = IDLE;
            end
         end
         KEYEXP: begin
            if (rc_last_s) begin
               state_n = DEC;
            end else begin
               state_n = KEYEXP;
            end
         end
         DEC: begin
            if (rc_first_s) begin
               state_n = FIN;
            end else begin
               state_n = DEC;
            end
         end
         FIN: begin
            state_n = DONE;
         end
         DONE: begin
            if (bus.out_ready) begin
               state_n = IDLE;
            end else begin
               state_n = DONE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Datapath: key expansion, round datapath and output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blk_r       <= 64'h0;
         key_r       <= 80'h0;
         rc_r        <= '0;
         out_data_r  <= 64'h0;
         out_valid_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  blk_r <= bus.in_data;
                  if (hit_s) begin
                     key_r <= hit_key_s;
                     rc_r  <= RC_LAST;
                  end else begin
                     key_r <= bus.in_key;
                     rc_r  <= RC_ONE;
                  end
               end
            end
            KEYEXP: begin
               key_r <= key_fwd_s;
               if (rc_last_s) begin
                  rc_r <= RC_LAST;
               end else begin
                  rc_r <= rc_r + RC_ONE;
               end
            end
            DEC: begin
               blk_r <= dec_s;
               key_r <= key_inv_s;
               // Holding at 1 on the last round keeps rc nonzero until IDLE.
               if (!rc_first_s) begin
                  rc_r <= rc_r - RC_ONE;
               end
            end
            FIN: begin
               out_data_r  <= blk_r ^ key_r[79:16];
               out_valid_r <= 1'b1;
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  rc_r        <= '0;
               end
            end
            default: begin
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.out_data  = out_data_r;

endmodule

// File: doc/present80_dec_core.md
Name: present80_dec_core

Overview:
- Iterative PRESENT-80 block decryptor: 64-bit ciphertext plus 80-bit key in, 64-bit plaintext out.
- Decryption counterpart of the team's PRESENT encryption datapath; one round per clock.
- Key expansion runs forward to K32 first, then the schedule is unwound in reverse alongside the rounds.
- Sits behind a valid/ready input channel and drives a valid/ready output channel.

Parameters:
ROUNDS, 31, number of cipher rounds; must stay 31 for standard vectors, lower values for reduced-round debug only
RC_W, 5, round-counter width; must satisfy 2**RC_W > ROUNDS

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  ciphertext/key valid
in_ready  out  1  core can accept a job
in_data  in  64  ciphertext, bit 63 = MSB
in_key  in  80  user key, bit 79 = MSB
out_valid  out  1  plaintext valid
out_ready  in  1  downstream accepts plaintext
out_data  out  64  plaintext, bit 63 = MSB

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, in_ready=1, out_valid=0, out_data=0, state/key/round registers=0.
- Reset mid-job aborts the job; nothing partial is ever emitted.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid&&in_ready, load state<=in_data, key<=in_key, rc<=1, go to KEYEXP.
  - KEYEXP: forward update each cycle, rc increments.
    - key<=key rotated left 61.
    - key[79:76]<=S(key[79:76]).
    - key[19:15]^=rc.
    - After ROUNDS cycles key=K32; rc<=ROUNDS; go to DEC.
  - DEC: each cycle state<=invS(invP(state^key[79:16])), then key<=inverse update with rc.
    - key[19:15]^=rc.
    - key[79:76]<=Sinv(key[79:76]).
    - key rotated right 61.
    - rc decrements. After ROUNDS cycles key=K1; go to FIN.
  - FIN: out_data<=state^key[79:16]; out_valid<=1; go to DONE.
  - DONE: hold out_data/out_valid stable until out_ready=1, then out_valid<=0, go to IDLE.
- in_ready=1 only in IDLE; no acceptance in the cycle the output is consumed.
- Latency: acceptance edge to out_valid high = 2*ROUNDS+1 edges (63 at default); throughput 1 job per 64+ cycles.
- invP: inverse of the PRESENT bit permutation P(i)=16i mod 63 (LSB numbering, bit 63 fixed); bit j of the input goes to position 4j mod 63, bit 63 stays.
- invS: per-nibble inverse PRESENT S-box, 16 nibbles, table 5,E,F,8,C,1,2,D,B,4,6,3,0,7,9,A.
- All XOR/rotate operations are width-exact; no carries.
- rc never wraps in a legal run; rc=0 is unreachable outside IDLE.
- in_data/in_key are sampled only on the acceptance edge; later changes are ignored.
- Back-to-back jobs: each job must be accepted in IDLE, and out_ready held high gives a 1-cycle DONE.

Optional Feature:
- Macro PRESENT_KEY_CACHE_EN.
- Defined:
  - Core keeps cache_key (80b), cache_k32 (80b) and cache_vld (reset 0).
  - On acceptance with cache_vld && in_key==cache_key: key<=cache_k32, rc<=ROUNDS, go directly to DEC (latency ROUNDS+1 = 32).
  - On a miss: KEYEXP as normal, and on KEYEXP->DEC capture cache_key<=accepted key and cache_k32<=K32, then set cache_vld.
  - Reset clears cache_vld.
- Undefined: no cache registers exist; latency is always 2*ROUNDS+1.

Decomposition:
- Package present_pkg holds:
  - SBOX and SBOX_INV 16x4 constant tables.
  - Default ROUNDS constant.
  - FSM state typedef (IDLE, KEYEXP, DEC, FIN, DONE).
  - Key-update and inverse-key-update functions.
- One combinational sub-module, present_inv_player (64b in, 64b out), instantiated once in the DEC datapath.

Test Plan:
- key=0, ct=5579C1387B228445 -> pt=0000000000000000; out_valid exactly 63 cycles after acceptance.
- key=FFFFFFFFFFFFFFFFFFFF, ct=E72C46C0F5945049 -> pt=0000000000000000.
- key=0, ct=A112FFC72F68417B -> pt=FFFFFFFFFFFFFFFF; out_ready held low 10 cycles -> out_data stable, in_ready=0 throughout.
- key=all F, ct=3333DCD3213210D2 -> pt=all F. Then with PRESENT_KEY_CACHE_EN, the same key and ct=E72C46C0F5945049 -> pt=0 with 32-cycle latency, and a different key -> 63 cycles.
- Assert rst_n low mid-DEC (cycle 40) -> out_valid=0, in_ready=1 immediately; next job key=0, ct=5579C1387B228445 decrypts correctly.
- in_data/in_key toggled every cycle after acceptance -> result unaffected; in_valid with in_ready=0 -> no second job taken.
